forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit.sv | 172 +++++++++++++++++
 tb/tb_forward_hazard_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// ----------------------------------------------------------------------------
// forward_hazard_unit
//
// Forwarding selector and load-use hazard detector for a five-stage pipeline.
// The unit keeps its own shadow copy of the EX, MEM and WB stages (plus WB1
// when the bypass is built in). From that copy it produces the EX-stage
// operand multiplexer selects, the load-use stall, and a count of stalls.
//
// Optional feature (compile-time macro):
//   WB_FORWARD_BYPASS_EN - adds the WB1 shadow stage and selector 11 (WB+1
//                          bypass). When it is undefined, the register file
//                          is taken to be write-before-read and 11 is never
//                          produced.
//
// Parameters:
//   CNT_BITS    - width of the saturating stall counter (default 16)
//
// Ports:
//   clk         - clock; all state updates on its rising edge
//   reset       - asynchronous active-high reset; clears every stage to a
//                 bubble and clears StallCount
//   ID_Rs/Rt    - source register numbers of the ID instruction
//   ID_UsesRs/Rt- ID instruction actually reads that source
//   ID_WriteReg - destination register of the ID instruction
//   ID_RegWrite - ID instruction writes the register file
//   ID_MemRead  - ID instruction is a load
//   Flush       - kill the ID instruction; a bubble enters EX instead
//   Hold        - global freeze; all state and StallCount hold, Stall=0
//   ForwardA/B  - EX operand selects: 00 regfile, 01 EX/MEM ALU result,
//                 10 MEM/WB writeback data, 11 WB+1 bypass
//   Stall       - hold PC and IF/ID, inject a bubble into EX
//   StallCount  - load-use stalls since reset, saturating at all-ones
// ----------------------------------------------------------------------------
module forward_hazard_unit #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          ID_Rs,
  input  logic [4:0]          ID_Rt,
  input  logic                ID_UsesRs,
  input  logic                ID_UsesRt,
  input  logic [4:0]          ID_WriteReg,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  input  logic                Hold,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                Stall,
  output logic [CNT_BITS-1:0] StallCount
);

  // Shadow copy of the fields of one pipeline stage that matter for hazards.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  typedef enum logic [1:0] {
    SEL_REGFILE = 2'b00,
    SEL_EXMEM   = 2'b01,
    SEL_MEMWB   = 2'b10,
    SEL_WB1     = 2'b11
  } fwd_sel_t;

  stage_t id_stage;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
`ifdef WB_FORWARD_BYPASS_EN
  stage_t wb1_q;
`endif

  logic hazard;
  logic stall_int;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  // True when stage s writes register src. Register 0 never matches, so
  // a source of $zero always resolves to the register file.
  function automatic logic writes_reg(input stage_t s, input logic [4:0] src);
    return s.reg_write && (src != 5'd0) && (s.write_reg == src);
  endfunction

  always_comb begin
    id_stage           = '0;
    id_stage.rs        = ID_Rs;
    id_stage.rt        = ID_Rt;
    id_stage.uses_rs   = ID_UsesRs;
    id_stage.uses_rt   = ID_UsesRt;
    id_stage.write_reg = ID_WriteReg;
    id_stage.reg_write = ID_RegWrite;
    id_stage.mem_read  = ID_MemRead;
  end

  // Load in EX whose destination is consumed by the ID instruction.
  always_comb begin
    hazard = 1'b0;
    if (ex_q.mem_read && (ex_q.write_reg != 5'd0)) begin
      if (ID_UsesRs && (ID_Rs == ex_q.write_reg)) hazard = 1'b1;
      if (ID_UsesRt && (ID_Rt == ex_q.write_reg)) hazard = 1'b1;
    end
  end

  // Hold freezes the pipe and Flush discards the consumer, so neither can
  // coexist with a stall.
  assign stall_int = hazard && !Hold && !Flush;
  assign Stall     = stall_int;

  // Most recent producer wins: MEM before WB before WB1.
  always_comb begin
    sel_a = SEL_REGFILE;
    sel_b = SEL_REGFILE;
    if (ex_q.uses_rs) begin
      if (writes_reg(mem_q, ex_q.rs))      sel_a = SEL_EXMEM;
      else if (writes_reg(wb_q, ex_q.rs))  sel_a = SEL_MEMWB;
`ifdef WB_FORWARD_BYPASS_EN
      else if (writes_reg(wb1_q, ex_q.rs)) sel_a = SEL_WB1;
`endif
    end
    if (ex_q.uses_rt) begin
      if (writes_reg(mem_q, ex_q.rt))      sel_b = SEL_EXMEM;
      else if (writes_reg(wb_q, ex_q.rt))  sel_b = SEL_MEMWB;
`ifdef WB_FORWARD_BYPASS_EN
      else if (writes_reg(wb1_q, ex_q.rt)) sel_b = SEL_WB1;
`endif
    end
  end

  assign ForwardA = sel_a;
  assign ForwardB = sel_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
`ifdef WB_FORWARD_BYPASS_EN
      wb1_q      <= '0;
`endif
      StallCount <= '0;
    end else if (!Hold) begin
      ex_q  <= (stall_int || Flush) ? stage_t'('0) : id_stage;
      mem_q <= ex_q;
      wb_q  <= mem_q;
`ifdef WB_FORWARD_BYPASS_EN
      wb1_q <= wb_q;
`endif
      if (stall_int && (StallCount != '1))
        StallCount <= StallCount + CNT_BITS'(1);
    end
  end

  // The oldest stage only needs its destination fields; the source fields
  // are carried so every shadow stage has the same shape.
`ifdef WB_FORWARD_BYPASS_EN
  logic wb1_unused;
  assign wb1_unused = ^{wb1_q.rs, wb1_q.rt, wb1_q.uses_rs, wb1_q.uses_rt,
                        wb1_q.mem_read};
`else
  logic wb_unused;
  assign wb_unused = ^{wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt,
                       wb_q.mem_read};
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  localparam int unsigned CNT_BITS = 2;

  logic                clk;
  logic                reset;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic [4:0]          id_write_reg;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic                hold;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic                stall;
  logic [CNT_BITS-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  forward_hazard_unit #(.CNT_BITS(CNT_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_Rs       (id_rs),
    .ID_Rt       (id_rt),
    .ID_UsesRs   (id_uses_rs),
    .ID_UsesRt   (id_uses_rt),
    .ID_WriteReg (id_write_reg),
    .ID_RegWrite (id_reg_write),
    .ID_MemRead  (id_mem_read),
    .Flush       (flush),
    .Hold        (hold),
    .ForwardA    (fwd_a),
    .ForwardB    (fwd_b),
    .Stall       (stall),
    .StallCount  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one ID instruction.
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] wr, input logic rw, input logic mr);
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_write_reg = wr;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance through one rising edge; returns 1 time unit after the next
  // falling edge so outputs are sampled far from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    hold  = 1'b0;
    nop();
    tick();

    // Reset state
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall", stall, 0);
    chk("rst_count", stall_count, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_fwd_a", fwd_a, 0);
    chk("post_rst_stall", stall, 0);
    tick();

    // ALU dependency: add $8 then consumer reads $8 as rs
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    set_id(5'd8, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    chk("alu_no_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("alu_fwd_a", fwd_a, 1);
    chk("alu_fwd_b", fwd_b, 0);
    chk("alu_stall_ex", stall, 0);
    tick();

    // Load-use: lw $9 then add reading $9 as rt
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(5'd6, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_count_before", stall_count, 0);
    tick();
    chk("lu_stall_once", stall, 0);
    chk("lu_count_after", stall_count, 1);
    tick();
    nop();
    #1;
    chk("lu_fwd_b", fwd_b, 2);
    chk("lu_fwd_a", fwd_a, 0);
    tick();

    // Double match: $10 written by both MEM and WB instructions
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(5'd10, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    chk("dbl_fwd_a", fwd_a, 1);
    chk("dbl_fwd_b", fwd_b, 1);
    tick();

    // $zero: producer writes $0, consumer reads $0
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    chk("zero_fwd_a", fwd_a, 0);
    chk("zero_fwd_b", fwd_b, 0);
    // Load to $0 followed by a reader of $0
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    chk("zero_load_stall", stall, 0);
    tick();
    // Source not used: no forwarding even on a match
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    set_id(5'd11, 5'd11, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    #1;
    chk("unused_rs_fwd_a", fwd_a, 0);
    chk("used_rt_fwd_b", fwd_b, 1);
    chk("zero_count", stall_count, 1);
    tick();

    // Flush with a hazard present; the flushed instruction is itself a load
    // of $13 so its leaking into EX would be visible.
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
    tick();
    set_id(5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_count", stall_count, 1);
    set_id(5'd13, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    chk("flush_ex_bubble_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("flush_mem_bubble_fwd", fwd_a, 0);
    tick();

    // Hold mid-hazard: lw $14 (rs=$15 forwarded from MEM), consumer reads $14
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    tick();
    set_id(5'd15, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd14, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    chk("hold_pre_stall", stall, 1);
    chk("hold_pre_fwd_a", fwd_a, 1);
    hold = 1'b1;
    #1;
    chk("hold_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_cyc%0d_stall", i), stall, 0);
      chk($sformatf("hold_cyc%0d_fwd_a", i), fwd_a, 1);
      chk($sformatf("hold_cyc%0d_count", i), stall_count, 1);
    end
    hold = 1'b0;
    #1;
    chk("hold_release_stall", stall, 1);
    tick();
    chk("hold_count", stall_count, 2);
    chk("hold_bubble_stall", stall, 0);
    tick();
    nop();
    #1;
    chk("hold_fwd_b", fwd_b, 2);
    tick();

    // Saturation with a 2-bit counter: three more stalls, five in total
    exp_cnt = 2;
    for (int i = 0; i < 3; i++) begin
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);
      tick();
      set_id(5'd16, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
      tick();
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      chk($sformatf("sat_count%0d", i), stall_count, exp_cnt);
      tick();
    end
    nop();
    chk("sat_final", stall_count, 3);

    // Reset in the middle of a stall abandons it
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b1);
    tick();
    set_id(5'd17, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    #1;
    chk("rst_mid_pre_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_count", stall_count, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_after_stall", stall, 0);
    chk("rst_mid_after_fwd", fwd_a, 0);
    tick();

    // Producer three instructions ahead: only the WB+1 bypass can see it
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    tick();
    set_id(5'd18, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    #1;
`ifdef WB_FORWARD_BYPASS_EN
    chk("wb1_fwd_a", fwd_a, 3);
`else
    chk("wb1_fwd_a", fwd_a, 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
